// File: rtl/timer_irq_src_pkg.sv
// Shared constants and types for the memory-mapped down-counter timer.
// Register offsets, CTRL bit positions, mode codes and FSM state encoding.
package timer_irq_src_pkg;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam int EN_B     = 0;
    localparam int MODE_LSB = 1;
    localparam int IM_B     = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_irq_src.sv
// Down-counter timer on the device bus; irq feeds one CP0 HWInt bit.
// Mode 0 holds irq until a CTRL/PRESET write, mode 1 pulses and auto-reloads.
module timer_irq_src
    import timer_irq_src_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_flag;
    state_e           r_state;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_flag_set;
    logic             w_flag_clr_fsm;
    logic             w_en_clr;
    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_en;
    logic             w_auto;

    // Bus protocol: single-cycle strobe, no handshake; a write takes effect on
    // the edge where we=1, reads are combinational from addr with no wait state.
    assign w_wr_ctrl   = we && (addr == CTRL_OFF);
    assign w_wr_preset = we && (addr == PRESET_OFF);
    assign w_en        = r_ctrl[EN_B];
    assign w_auto      = (r_ctrl[MODE_LSB +: 2] == MODE_AUTO);

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_flag_set     = 1'b0;
        w_flag_clr_fsm = 1'b0;
        w_en_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                // COUNT <= 1 also covers PRESET = 0, which then behaves as 1.
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > CNT_W'(1)) begin
                    w_count_nxt = r_count - CNT_W'(1);
                end else begin
                    w_count_nxt = '0;
                    w_flag_set  = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (w_auto) begin
                    w_flag_clr_fsm = 1'b1;
                end else begin
                    w_en_clr = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A bus write to CTRL overrides the one-shot EN clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= wdata[3:0];
        end else if (w_en_clr) begin
            r_ctrl[EN_B] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= '0;
        end else if (w_wr_preset) begin
            r_preset <= wdata[CNT_W-1:0];
        end
    end

    // Expiry beats a software clear landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag <= 1'b0;
        end else if (w_flag_set) begin
            r_flag <= 1'b1;
        end else if (w_wr_ctrl || w_wr_preset || w_flag_clr_fsm) begin
            r_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CTRL_OFF:   rdata[3:0]       = r_ctrl;
            PRESET_OFF: rdata[CNT_W-1:0] = r_preset;
            COUNT_OFF:  rdata[CNT_W-1:0] = r_count;
            default:    rdata            = '0;
        endcase
    end

    assign irq       = r_flag & r_ctrl[IM_B];
    assign dbg_state = r_state;

endmodule
